tff_bank_ctrl: RTL and testbench
================================

// Module: tff_bank_ctrl
// PURPOSE
//  Sequencer for a bank of WIDTH toggle flip-flops forming a programmable counter.
//  Computes per-bit toggle enables each cycle: count up/down, load, hold.
//  Provides start/stop/pause control, one-shot or auto-reload mode, terminal-count flag.
//  Sits between control logic and the T-FF bank; the bank is instantiated inside.
// PARAMETERS
//  WIDTH     4  number of T-FF bits in the bank / counter width
//  PRESCALE  4  enabled cycles per count step (used only with TFF_PRESCALE_EN), >=1
// PORTS
//  clk          in   1      single clock, all state updates on posedge
//  rst          in   1      synchronous reset, active-low
//  start        in   1      pulse; begins a run (accepted in IDLE/DONE only)
//  stop         in   1      pulse; aborts run, q holds its value
//  pause        in   1      level; freezes counting while high
//  mode_down    in   1      0: count 0->term; 1: count term->0 (sampled on start)
//  auto_reload  in   1      1: restart on terminal; 0: one-shot (sampled on start)
//  term         in   WIDTH  terminal/start value (sampled on start)
//  q            out  WIDTH  T-FF bank state
//  t_vec        out  WIDTH  toggle enables applied at next edge (combinational)
//  busy         out  1      high in RUN or PAUSE
//  tc           out  1      one-cycle pulse: terminal reached
//  done         out  1      one-cycle pulse: one-shot run complete
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE, q=0, tc=0, done=0, busy=0; overrides all inputs, mid-run too.
//  All changes to q happen via toggles: q_next = q ^ t_vec.
//  Load of value V: t_vec = q ^ V (one cycle). Up step: t_vec[i] = &q[i-1:0] (t_vec[0]=1).
//  Down step: t_vec[i] = ~|q[i-1:0] (t_vec[0]=1). Hold: t_vec = 0. Wrap is modulo 2^WIDTH.
//  States: IDLE, RUN, PAUSE, DONE.
//  IDLE/DONE + start: latch mode/reload/term; load start value (up: 0, down: term); -> RUN.
//  RUN, end value reached (up: q==term, down: q==0) on a step cycle:
//    tc pulses next cycle; auto_reload: load start value, stay RUN; else hold q, -> DONE.
//  RUN otherwise: step. RUN + pause: hold, -> PAUSE. PAUSE + !pause: -> RUN (no step that cycle).
//  DONE: done=1 for exactly that cycle; -> IDLE next cycle unless start.
//  Priority: rst > stop > pause > start. stop in RUN/PAUSE -> IDLE, q held, no tc/done.
//  start while busy: ignored. pause in IDLE/DONE: ignored.
//  Latency: start to first q update = 1 edge; one-shot up run takes term+1 RUN cycles.
//  term==0: q loads 0, next RUN cycle detects terminal -> tc and done.
// CONFIGURATION
//  TFF_PRESCALE_EN defined: a step/terminal check occurs only when the internal prescale
//    counter (0..PRESCALE-1) wraps; counter clears on start, freezes in PAUSE.
//    Loads are not prescaled.
//  TFF_PRESCALE_EN undefined: step every RUN cycle; PRESCALE ignored, no prescale logic.
// STRUCTURE
//  tff_ctrl_pkg: state enum (IDLE, RUN, PAUSE, DONE), 2-bit state encoding, op codes (HOLD/LOAD/STEP).
//  Sub-module tff_cell: one T-FF with sync active-low clear (clk, rst, t, q);
//    generate WIDTH instances. FSM + toggle logic stay in tff_bank_ctrl.
// TESTING
//  rst=0 mid-run at q=5 -> next edge q=0, busy=0, state IDLE; no tc/done.
//  WIDTH=4, up, one-shot, term=3, start -> q 0,1,2,3 then tc=1 and done=1 together, q holds 3.
//  down, auto_reload, term=2 -> q 2,1,0,2,1,0...; tc pulses once per 0; busy stays 1.
//  up, term=15, auto_reload -> 15 then reload to 0; t_vec=4'b1111 on the 7->8 step.
//  pause high 3 cycles at q=4 -> q stays 4, busy=1; release -> next step 5; stop at q=6 -> IDLE, q=6.
//  TFF_PRESCALE_EN, PRESCALE=4, up term=2 -> q advances every 4th cycle; start while busy ignored.

Source files
------------

// File: rtl/tff_ctrl_pkg.sv
// Shared types for the T-FF bank controller: FSM states and per-cycle bank operations.
package tff_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // What the bank does at the next edge: keep q, jump to a value, or count one step.
    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_STEP = 2'd2
    } op_t;

endpackage

// File: rtl/tff_bank_ctrl_cell.sv
// tff_cell: single toggle flip-flop with synchronous active-low clear.
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    logic r_q;

    // Toggle on t, clear when rst is low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q <= 1'b0;
        end else if (t) begin
            r_q <= ~r_q;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/tff_bank_ctrl.sv
// tff_bank_ctrl: sequencer driving a bank of WIDTH T-FFs as a programmable up/down counter.
// Every change of q goes through the toggle vector: q_next = q ^ t_vec.
// Optional feature macro: TFF_PRESCALE_EN -- when defined, counting steps and terminal
// checks happen only once per PRESCALE RUN cycles; loads are never prescaled.
// dbg_state exposes the FSM state for checkers.
module tff_bank_ctrl
    import tff_ctrl_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             mode_down,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] t_vec,
    output logic             busy,
    output logic             tc,
    output logic             done,
    output state_t           dbg_state
);

    state_t           r_state;
    state_t           w_next_state;
    op_t              w_op;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_up_t;
    logic [WIDTH-1:0] w_dn_t;
    logic             r_mode_down;
    logic             r_auto_reload;
    logic [WIDTH-1:0] r_term;
    logic             r_tc;
    logic             w_tc_set;
    logic             w_accept;
    logic             w_at_end;
    logic             w_step_en;

    if (PRESCALE < 1) begin : g_prescale_check
        $error("tff_bank_ctrl: PRESCALE must be >= 1");
    end

    // Ripple-carry/borrow toggle patterns: bit i flips when all lower bits are 1 (up) or 0 (down).
    assign w_up_t[0] = 1'b1;
    assign w_dn_t[0] = 1'b1;
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_carry
        assign w_up_t[gi] = &q[gi-1:0];
        assign w_dn_t[gi] = ~|q[gi-1:0];
    end

    // End of a run: up runs finish at the latched terminal, down runs at zero.
    assign w_at_end = r_mode_down ? (q == '0) : (q == r_term);

`ifdef TFF_PRESCALE_EN
    localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_pre;
    logic          w_pre_adv;

    assign w_step_en = (r_pre == PRE_LAST);
    // The prescaler only advances on RUN cycles that are neither stopped nor paused.
    assign w_pre_adv = (r_state == RUN) && ((w_next_state == RUN) || (w_next_state == DONE));

    // Prescale counter: cleared when a run starts, frozen outside active RUN cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pre <= '0;
        end else if (w_accept) begin
            r_pre <= '0;
        end else if (w_pre_adv) begin
            r_pre <= w_step_en ? '0 : r_pre + 1'b1;
        end
    end
`else
    assign w_step_en = 1'b1;
`endif

    // FSM state register, terminal-count pulse and run parameters latched on start.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_tc          <= 1'b0;
            r_mode_down   <= 1'b0;
            r_auto_reload <= 1'b0;
            r_term        <= '0;
        end else begin
            r_state <= w_next_state;
            r_tc    <= w_tc_set;
            if (w_accept) begin
                r_mode_down   <= mode_down;
                r_auto_reload <= auto_reload;
                r_term        <= term;
            end
        end
    end

    // Next state and bank operation; stop beats pause beats start.
    always_comb begin
        w_next_state = r_state;
        w_op         = OP_HOLD;
        w_load_val   = q;
        w_tc_set     = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                w_next_state = IDLE;
                if (start && !stop) begin
                    w_next_state = RUN;
                    w_op         = OP_LOAD;
                    w_load_val   = mode_down ? term : '0;
                    w_accept     = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    w_next_state = IDLE;
                end else if (pause) begin
                    w_next_state = PAUSE;
                end else if (w_step_en) begin
                    if (w_at_end) begin
                        w_tc_set = 1'b1;
                        if (r_auto_reload) begin
                            w_op       = OP_LOAD;
                            w_load_val = r_mode_down ? r_term : '0;
                        end else begin
                            w_next_state = DONE;
                        end
                    end else begin
                        w_op = OP_STEP;
                    end
                end
            end
            PAUSE: begin
                if (stop) begin
                    w_next_state = IDLE;
                end else if (!pause) begin
                    w_next_state = RUN;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Translate the selected operation into per-bit toggle enables.
    always_comb begin
        t_vec = '0;
        case (w_op)
            OP_LOAD: t_vec = q ^ w_load_val;
            OP_STEP: t_vec = r_mode_down ? w_dn_t : w_up_t;
            default: t_vec = '0;
        endcase
    end

    for (genvar gb = 0; gb < WIDTH; gb++) begin : g_bank
        tff_cell u_cell (
            .clk (clk),
            .rst (rst),
            .t   (t_vec[gb]),
            .q   (q[gb])
        );
    end

    assign busy      = (r_state == RUN) || (r_state == PAUSE);
    assign tc        = r_tc;
    assign done      = (r_state == DONE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_tff_bank_ctrl.sv
// Testbench for tff_bank_ctrl: vector table, directed multi-cycle sequences and
// random stimulus checked against an arithmetic reference model.
module tb_tff_bank_ctrl;
    import tff_ctrl_pkg::*;

    localparam int W        = 4;
    localparam int PRESCALE = 4;
    localparam int MOD      = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         stop;
    logic         pause;
    logic         mode_down;
    logic         auto_reload;
    logic [W-1:0] term;
    logic [W-1:0] q;
    logic [W-1:0] t_vec;
    logic         busy;
    logic         tc;
    logic         done;
    state_t       dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: counter value as an integer plus run flags.
    int m_q;
    bit m_busy;
    bit m_paused;
    bit m_done;
    bit m_tc;
    bit m_down;
    bit m_ar;
    int m_term;
    int m_pre;

    typedef struct {
        bit s;
        bit sp;
        bit p;
        bit md;
        bit ar;
        int tm;
        int eq;
        int et;
        bit eb;
        bit etc;
        bit ed;
    } vec_t;

    vec_t tbl[17];

    tff_bank_ctrl #(
        .WIDTH    (W),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .mode_down   (mode_down),
        .auto_reload (auto_reload),
        .term        (term),
        .q           (q),
        .t_vec       (t_vec),
        .busy        (busy),
        .tc          (tc),
        .done        (done),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        m_q      = 0;
        m_busy   = 0;
        m_paused = 0;
        m_done   = 0;
        m_tc     = 0;
        m_pre    = 0;
    endtask

    // One clock cycle: drive inputs at the falling edge, compare outputs against the
    // model, then advance the model to what the next rising edge should produce.
    task automatic apply(input bit r, input bit s, input bit sp, input bit p,
                         input bit md, input bit ar, input int tm);
        int     nq;
        bit     nbusy, npaused, ndone, ntc, step_ok, hit;
        state_t exp_st;
        @(negedge clk);
        rst = r; start = s; stop = sp; pause = p;
        mode_down = md; auto_reload = ar; term = W'(tm);
        #1;
        exp_st = m_busy ? (m_paused ? PAUSE : RUN) : (m_done ? DONE : IDLE);
        check("q", 32'(q), 32'(m_q));
        check("busy", 32'(busy), 32'(m_busy));
        check("tc", 32'(tc), 32'(m_tc));
        check("done", 32'(done), 32'(m_done));
        check("state", 32'(dbg_state), 32'(exp_st));
        nq = m_q; nbusy = m_busy; npaused = m_paused; ndone = 0; ntc = 0;
        if (!r) begin
            nq = 0; nbusy = 0; npaused = 0; m_pre = 0;
        end else if (!m_busy) begin
            if (s && !sp) begin
                m_down = md; m_ar = ar; m_term = tm % MOD;
                nq = md ? m_term : 0;
                nbusy = 1; npaused = 0; m_pre = 0;
            end
        end else if (sp) begin
            nbusy = 0; npaused = 0;
        end else if (m_paused) begin
            if (!p) npaused = 0;
        end else if (p) begin
            npaused = 1;
        end else begin
`ifdef TFF_PRESCALE_EN
            step_ok = (m_pre == PRESCALE - 1);
            m_pre   = step_ok ? 0 : m_pre + 1;
`else
            step_ok = 1;
`endif
            if (step_ok) begin
                hit = m_down ? (m_q == 0) : (m_q == m_term);
                if (hit) begin
                    ntc = 1;
                    if (m_ar) nq = m_down ? m_term : 0;
                    else begin
                        nbusy = 0; ndone = 1;
                    end
                end else begin
                    nq = m_down ? (m_q + MOD - 1) % MOD : (m_q + 1) % MOD;
                end
            end
        end
        if (r) check("t_vec", 32'(t_vec), 32'(m_q ^ nq));
        m_q = nq; m_busy = nbusy; m_paused = npaused; m_done = ndone; m_tc = ntc;
    endtask

    task automatic quiet();
        apply(1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit found;

        // Clock/reset
        rst = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        mode_down = 1'b0; auto_reload = 1'b0; term = '0;
        repeat (2) @(posedge clk);
        model_reset();

        // Reset state
        quiet();
        check("rst_q", 32'(q), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_tc", 32'(tc), 0);
        check("rst_done", 32'(done), 0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));

`ifndef TFF_PRESCALE_EN
        // Up one-shot term=3, then down auto-reload term=2 ended by stop.
        tbl[0]  = '{1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 1, 3, 1, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0};
        tbl[4]  = '{0, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 3, 0, 0, 1, 1};
        tbl[6]  = '{0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0};
        tbl[7]  = '{1, 0, 0, 1, 1, 2, 3, 1, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 2, 3, 1, 0, 0};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0};
        tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 2, 3, 1, 1, 0};
        tbl[12] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0};
        tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0};
        tbl[14] = '{0, 0, 0, 0, 0, 0, 2, 3, 1, 1, 0};
        tbl[15] = '{0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0};
        tbl[16] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        for (int i = 0; i < 17; i++) begin
            apply(1, tbl[i].s, tbl[i].sp, tbl[i].p, tbl[i].md, tbl[i].ar, tbl[i].tm);
            check($sformatf("tbl%0d_q", i), 32'(q), 32'(tbl[i].eq));
            check($sformatf("tbl%0d_t", i), 32'(t_vec), 32'(tbl[i].et));
            check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].eb));
            check($sformatf("tbl%0d_tc", i), 32'(tc), 32'(tbl[i].etc));
            check($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].ed));
        end

        // Reset in the middle of a run at q=5.
        apply(1, 1, 0, 0, 0, 0, 9);
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            quiet();
            if (q == 4) found = 1;
        end
        check("wait_q4", 32'(found), 1);
        apply(0, 0, 0, 0, 0, 0, 0);
        check("midrst_q_before", 32'(q), 5);
        quiet();
        check("midrst_q", 32'(q), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_tc", 32'(tc), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_state", 32'(dbg_state), 32'(IDLE));

        // Full-range up run with auto-reload: all bits toggle on 7->8, 15 wraps to 0.
        apply(1, 1, 0, 0, 0, 1, 15);
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            quiet();
            if (q == 7) check("t_7to8", 32'(t_vec), 32'hF);
            if (q == 15) found = 1;
        end
        check("wait_q15", 32'(found), 1);
        quiet();
        check("reload_q", 32'(q), 0);
        check("reload_tc", 32'(tc), 1);
        check("reload_busy", 32'(busy), 1);
        apply(1, 0, 1, 0, 0, 0, 0);
        quiet();

        // Pause for three cycles at q=4, release, start-while-busy, stop at q=6.
        apply(1, 1, 0, 0, 0, 0, 9);
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            quiet();
            if (q == 3) found = 1;
        end
        check("wait_q3", 32'(found), 1);
        for (int k = 0; k < 3; k++) begin
            apply(1, 0, 0, 1, 0, 0, 0);
            check($sformatf("pause%0d_q", k), 32'(q), 4);
            check($sformatf("pause%0d_busy", k), 32'(busy), 1);
        end
        apply(1, 0, 0, 0, 0, 0, 0);
        check("release_state", 32'(dbg_state), 32'(PAUSE));
        quiet();
        check("resume_q", 32'(q), 4);
        check("resume_state", 32'(dbg_state), 32'(RUN));
        apply(1, 1, 0, 0, 1, 0, 1);
        check("step5_q", 32'(q), 5);
        apply(1, 0, 1, 0, 0, 0, 0);
        check("stop_at_q", 32'(q), 6);
        quiet();
        check("stopped_q", 32'(q), 6);
        check("stopped_busy", 32'(busy), 0);
        check("stopped_tc", 32'(tc), 0);
        check("stopped_done", 32'(done), 0);
        check("stopped_state", 32'(dbg_state), 32'(IDLE));

        // term==0 one-shot: terminal found on the first RUN cycle.
        apply(1, 1, 0, 0, 0, 0, 0);
        quiet();
        quiet();
        check("t0_tc", 32'(tc), 1);
        check("t0_done", 32'(done), 1);
`else
        // Prescaled up run to 2 with a start attempt while busy.
        apply(1, 1, 0, 0, 0, 0, 2);
        for (int k = 0; k < 6; k++) quiet();
        apply(1, 1, 0, 0, 1, 1, 7);
        for (int k = 0; k < 10; k++) quiet();
`endif

        // Random stimulus against the model.
        for (int k = 0; k < 400; k++) begin
            apply($urandom_range(0, 63) != 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, MOD - 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
